data_mem_responder: RTL
=======================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, SHALL set the data RAM size in 32-bit words (power of two).
REQ-002 Parameter MMIO_BASE, default 32'hFFFF_0000, SHALL set the I/O page base address.
REQ-003 The block SHALL run on one clock; reset is synchronous and active-high.
REQ-004 Ports SHALL be:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high
- Address  input  32  byte address of the MEM-stage access
- MemWrite  input  2  store request; any nonzero value means store
- WriteMemData  input  32  store data, right-aligned
- WriteMemDataLength  input  3  001 byte, 010 half, 100 word; others mean no store
- ReadMemData  output  32  aligned word at Address, combinational
- TxValid  output  1  TX FIFO head valid
- TxData  output  8  TX FIFO head byte
- TxReady  input  1  consumer accepts the head byte
- MemError  output  1  sticky error flag (misalign or overflow)

Function
REQ-005 RAM SHALL occupy addresses 0 to DEPTH_WORDS*4-1 and be indexed by Address[log2(DEPTH_WORDS)+1:2].
REQ-006 ReadMemData SHALL be the full aligned word, read combinationally with zero cycles of latency; sign and zero extension is done by the core.
REQ-007 Reads of unmapped addresses SHALL return 32'h0; stores to unmapped addresses SHALL be ignored.
REQ-008 Stores SHALL commit on the rising clock edge.
REQ-009 Byte stores SHALL write WriteMemData[7:0] to the lane selected by Address[1:0] (lane 0 = bits 7:0).
REQ-010 Half stores SHALL write WriteMemData[15:0] to lanes selected by Address[1] (0 = bits 15:0).
REQ-011 Word stores SHALL write all lanes and ignore Address[1:0].
REQ-012 A half store with Address[0]=1, or a word store with Address[1:0]!=0, SHALL be suppressed and set the sticky MISALIGN flag.
REQ-013 MMIO_BASE+0 (CYCLE) SHALL be read-only: a free-running 32-bit counter that increments every non-reset cycle and wraps from FFFF_FFFF to 0.
REQ-014 MMIO_BASE+4 (TXDATA) SHALL push WriteMemData[7:0] into a 4-entry FIFO on any store length, and SHALL read back 0.
REQ-015 MMIO_BASE+8 (STATUS) SHALL read as follows:
- bit0 full
- bit1 empty
- bits4:2 count (0 to 4)
- bit5 MISALIGN
- bit6 OVERFLOW
- all other bits 0
REQ-016 Any store to STATUS SHALL clear MISALIGN and OVERFLOW.
REQ-017 TxValid SHALL equal not-empty, and TxData SHALL be the head entry.
REQ-018 A pop SHALL occur on an edge where TxValid and TxReady are both 1.
REQ-019 A push to a full FIFO SHALL be dropped and set OVERFLOW, except when a pop occurs in the same cycle; then the push SHALL be accepted and count stays 4.
REQ-020 A simultaneous push and pop on a non-full FIFO SHALL leave count unchanged and preserve FIFO order.
REQ-021 Read and write pointers SHALL wrap modulo 4.
REQ-022 MemError SHALL equal MISALIGN OR OVERFLOW, registered.
REQ-023 A store to STATUS in the same cycle as a new error SHALL leave the new error flag set (set wins).

Reset
REQ-024 When reset is 1 on an edge, the block SHALL clear the CYCLE counter, FIFO pointers, count, MISALIGN and OVERFLOW.
REQ-025 After reset, outputs SHALL be TxValid=0, TxData=0 and MemError=0.
REQ-026 RAM contents SHALL NOT be reset.
REQ-027 Stores presented in a reset cycle SHALL be ignored, including RAM stores.
REQ-028 Reset asserted while the FIFO holds data SHALL discard all entries, with TxValid=0 on the next cycle.

Configuration
REQ-029 Macro DMEM_CYCLE_COUNTER_EN SHALL control the CYCLE counter.
- Defined: CYCLE behaves per REQ-013.
- Undefined: no counter register is built, and reads of MMIO_BASE+0 return 32'h0.
- All other behaviour is identical in both builds.

Verification
REQ-030 Word store 32'h1122_3344 to 0x10, then byte store 8'hAA to 0x11 -> read 0x10 returns 32'h1122_AA44.
REQ-031 Half store 16'hBEEF to 0x22 -> read 0x20 returns 32'hBEEF_xxxx (upper half updated); half store to 0x23 -> word unchanged, STATUS bit5=1, MemError=1.
REQ-032 Five TXDATA pushes (01..05) with TxReady=0 -> STATUS reads 32'h0000_0051 (full, count 4, OVERFLOW), and TxData=01.
REQ-033 Full FIFO with TxReady=1 and a push of 8'h06 in the same cycle -> count stays 4, OVERFLOW stays clear, drain order is 02,03,04,06.
REQ-034 Reset held 1 cycle after 10 cycles, then 5 cycles run -> CYCLE reads 5 with DMEM_CYCLE_COUNTER_EN defined and 0 without it; RAM word at 0x10 is retained.
REQ-035 Store to STATUS while MemError=1 -> MemError=0 on the next cycle; read of unmapped address 0x8000_0000 returns 0.

Source files
------------

// File: rtl/data_mem_responder.sv
// Data-memory responder: byte-addressable word RAM plus an MMIO page with a cycle
// counter, a 4-entry TX byte FIFO and a sticky error/status register (DMEM_CYCLE_COUNTER_EN).
module data_mem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [1:0]  MemWrite,
    input  logic [31:0] WriteMemData,
    input  logic [2:0]  WriteMemDataLength,
    output logic [31:0] ReadMemData,
    output logic        TxValid,
    output logic [7:0]  TxData,
    input  logic        TxReady,
    output logic        MemError
);
    localparam int          AW          = $clog2(DEPTH_WORDS);
    localparam logic [31:0] CYCLE_ADDR  = MMIO_BASE;
    localparam logic [31:0] TXDATA_ADDR = MMIO_BASE + 32'd4;
    localparam logic [31:0] STATUS_ADDR = MMIO_BASE + 32'd8;

    logic [31:0]   ram [DEPTH_WORDS];
    logic [AW-1:0] ramIdx;
    logic          ramHit;
    logic          isByte, isHalf, isWord;
    logic          storeReq, storeOk, misalignNow, ramWe;
    logic [3:0]    laneEn;
    logic [31:0]   laneData;

    logic [7:0]    fifo [4];
    logic [1:0]    rdPtr, wrPtr;
    logic [2:0]    count;
    logic          full, empty, pushReq, pushAcc, pop, overflowNow;
    logic          misalign, overflow, misalignNext, overflowNext, statusClr;
    logic          memErrorReg;
    logic [31:0]   cycleRead;

    assign ramIdx = Address[AW+1:2];
    assign ramHit = (Address[31:AW+2] == '0);
    assign isByte = (WriteMemDataLength == 3'b001);
    assign isHalf = (WriteMemDataLength == 3'b010);
    assign isWord = (WriteMemDataLength == 3'b100);

    // Reset cycles swallow every store, RAM included.
    assign storeReq    = (MemWrite != 2'b00) && (isByte || isHalf || isWord) && !reset;
    assign misalignNow = storeReq && ((isHalf && Address[0]) || (isWord && (Address[1:0] != 2'b00)));
    assign storeOk     = storeReq && !misalignNow;
    assign ramWe       = storeOk && ramHit;

    always_comb begin
        laneEn   = 4'b1111;
        laneData = WriteMemData;
        if (isByte) begin
            laneEn           = 4'b0000;
            laneEn[Address[1:0]] = 1'b1;
            laneData         = {4{WriteMemData[7:0]}};
        end else if (isHalf) begin
            laneEn   = Address[1] ? 4'b1100 : 4'b0011;
            laneData = {2{WriteMemData[15:0]}};
        end
    end

    always_ff @(posedge clock) begin
        if (ramWe) begin
            for (int i = 0; i < 4; i++) begin
                if (laneEn[i]) ram[ramIdx][i*8 +: 8] <= laneData[i*8 +: 8];
            end
        end
    end

    assign full        = (count == 3'd4);
    assign empty       = (count == 3'd0);
    assign pushReq     = storeOk && (Address == TXDATA_ADDR);
    assign pop         = !empty && TxReady;
    // A full FIFO still takes a push when the head leaves on the same edge.
    assign pushAcc     = pushReq && (!full || pop);
    assign overflowNow = pushReq && full && !pop;
    assign statusClr   = storeOk && (Address == STATUS_ADDR);

    // New errors win over a clearing store in the same cycle.
    assign misalignNext = (misalign && !statusClr) || misalignNow;
    assign overflowNext = (overflow && !statusClr) || overflowNow;

    always_ff @(posedge clock) begin
        if (reset) begin
            rdPtr       <= 2'd0;
            wrPtr       <= 2'd0;
            count       <= 3'd0;
            misalign    <= 1'b0;
            overflow    <= 1'b0;
            memErrorReg <= 1'b0;
        end else begin
            if (pushAcc) wrPtr <= wrPtr + 2'd1;
            if (pop)     rdPtr <= rdPtr + 2'd1;
            count       <= count + {2'b00, pushAcc} - {2'b00, pop};
            misalign    <= misalignNext;
            overflow    <= overflowNext;
            memErrorReg <= misalignNext || overflowNext;
        end
    end

    always_ff @(posedge clock) begin
        if (pushAcc) fifo[wrPtr] <= WriteMemData[7:0];
    end

`ifdef DMEM_CYCLE_COUNTER_EN
    logic [31:0] cycleCount;
    always_ff @(posedge clock) begin
        if (reset) cycleCount <= 32'd0;
        else       cycleCount <= cycleCount + 32'd1;
    end
    assign cycleRead = cycleCount;
`else
    assign cycleRead = 32'd0;
`endif

    always_comb begin
        ReadMemData = 32'd0;
        if (ramHit)                     ReadMemData = ram[ramIdx];
        else if (Address == CYCLE_ADDR)  ReadMemData = cycleRead;
        else if (Address == STATUS_ADDR) ReadMemData = {25'd0, overflow, misalign, count, empty, full};
    end

    assign TxValid  = !empty;
    assign TxData   = empty ? 8'h00 : fifo[rdPtr];
    assign MemError = memErrorReg;
endmodule
